min_hour_cnt: RTL and testbench
===============================

MIN_HOUR_CNT -- requirements
Module: min_hour_cnt

Interface
REQ-001 Parameters: none; all limits are fixed at 59 minutes and 23 hours.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 sec_oc  in  1  one-cycle carry pulse from the seconds counter stage, high once per seconds wrap 59->00.
REQ-005 key_mode  in  1  one-cycle pulse (already debounced); advances the mode.
REQ-006 key_inc  in  1  one-cycle pulse (already debounced); increments the selected field in set modes.
REQ-007 min_1  out  4  BCD minutes units, 0-9.
REQ-008 min_2  out  4  BCD minutes tens, 0-5.
REQ-009 hour_1  out  4  BCD hours units, 0-9.
REQ-010 hour_2  out  4  BCD hours tens, 0-2.
REQ-011 mode  out  2  current mode: 0=RUN, 1=SET_HOUR, 2=SET_MIN.
REQ-012 hour_oc  out  1  one-cycle day-wrap pulse.

Function
REQ-013 FSM transitions on key_mode: RUN->SET_HOUR->SET_MIN->RUN; with no key_mode, the mode holds.
REQ-014 RUN, sec_oc high: minutes increment in BCD; the new value is visible on the outputs 1 cycle after the sampling edge.
REQ-015 Minute carry: min_1 9->0 increments min_2; 59->00 increments the hours.
REQ-016 Hour wrap: hours 09->10, 19->20, 23->00.
REQ-017 Day wrap: on 23:59->00:00 in RUN, hour_oc is high for exactly the one cycle in which the outputs show 00:00; hour_oc is 0 at all other times.
REQ-018 SET_HOUR: sec_oc is ignored and minutes are frozen; key_inc increments hours, 23->00, with no hour_oc pulse.
REQ-019 SET_MIN: sec_oc is ignored and hours are frozen; key_inc increments minutes, 59->00, with no hour carry.
REQ-020 key_inc in RUN is ignored.
REQ-021 key_mode and key_inc in the same cycle: the mode advances and key_inc is discarded.
REQ-022 sec_oc and key_mode in the same cycle while in RUN: the count increments and the mode advances to SET_HOUR.
REQ-023 Only legal BCD values are reachable; no output ever shows a digit outside the ranges in REQ-007 to REQ-010.
REQ-024 All outputs are registered; no combinational input-to-output path exists.

Reset
REQ-025 rst_n low at an edge: min_1, min_2, hour_1 and hour_2 become 0, mode becomes RUN, hour_oc becomes 0, and alarm_hit (when present) becomes 0.
REQ-026 Reset has priority over every input, including when it is asserted mid-set or in the same cycle as sec_oc or key pulses.
REQ-027 The first count is accepted on the first edge at which rst_n is high.

Configuration
REQ-028 Macro MIN_HOUR_ALARM_EN is defined: add inputs al_hour_2, al_hour_1, al_min_2 and al_min_1 (each 4-bit BCD), and output alarm_hit (1 bit).
REQ-029 With the macro defined, alarm_hit pulses high for one cycle, aligned with the updated outputs, when a RUN-mode minute increment produces a time equal to the alarm inputs.
REQ-030 With the macro defined, changes made in a set mode never assert alarm_hit.
REQ-031 Macro undefined: the alarm ports and logic are absent, and all other behaviour is identical.

Verification
REQ-032 Reset, then 60 sec_oc pulses spaced 3 cycles apart -> outputs 01:00, hour_oc never high.
REQ-033 Set the time to 23:59 via the set modes, return to RUN, pulse sec_oc -> next cycle outputs 00:00 with hour_oc=1, and hour_oc=0 on the following cycle.
REQ-034 key_mode once, 25 key_inc pulses interleaved with 10 sec_oc pulses -> hour 01, minutes unchanged, mode=1.
REQ-035 In SET_MIN at 12:59, key_inc -> 12:00; key_mode and key_inc in the same cycle -> mode=0, minutes unchanged.
REQ-036 rst_n low for 1 cycle while in SET_MIN at 07:33 -> 00:00, mode=0; a sec_oc on the same edge is ignored.
REQ-037 MIN_HOUR_ALARM_EN defined, alarm set to 00:02, from reset pulse sec_oc twice -> alarm_hit=1 for exactly one cycle with outputs 00:02.

Source files
------------

// File: rtl/min_hour_cnt_if.sv
// Pulse and display bundle for the minutes/hours clock stage.
// Defining MIN_HOUR_ALARM_EN adds the alarm compare inputs and the alarm_hit output.
interface min_hour_cnt_if;
  // sec_oc, key_mode and key_inc are single-cycle strobes with no ready:
  // a strobe is consumed on the one rising edge where it is high.
  logic       sec_oc;
  logic       key_mode;
  logic       key_inc;
  logic [3:0] min_1;
  logic [3:0] min_2;
  logic [3:0] hour_1;
  logic [3:0] hour_2;
  logic [1:0] mode;
  logic       hour_oc;
`ifdef MIN_HOUR_ALARM_EN
  logic [3:0] al_hour_2;
  logic [3:0] al_hour_1;
  logic [3:0] al_min_2;
  logic [3:0] al_min_1;
  logic       alarm_hit;

  modport master (
    output sec_oc, key_mode, key_inc, al_hour_2, al_hour_1, al_min_2, al_min_1,
    input  min_1, min_2, hour_1, hour_2, mode, hour_oc, alarm_hit
  );
  modport slave (
    input  sec_oc, key_mode, key_inc, al_hour_2, al_hour_1, al_min_2, al_min_1,
    output min_1, min_2, hour_1, hour_2, mode, hour_oc, alarm_hit
  );
`else
  modport master (
    output sec_oc, key_mode, key_inc,
    input  min_1, min_2, hour_1, hour_2, mode, hour_oc
  );
  modport slave (
    input  sec_oc, key_mode, key_inc,
    output min_1, min_2, hour_1, hour_2, mode, hour_oc
  );
`endif
endinterface

// File: rtl/min_hour_cnt.sv
// BCD minutes/hours counter with RUN / SET_HOUR / SET_MIN modes and a day-wrap pulse.
// Optional alarm compare is built when MIN_HOUR_ALARM_EN is defined.
module min_hour_cnt (
    input logic          clk,
    input logic          rst_n,
    min_hour_cnt_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    mode_e      state;
    mode_e      state_nxt;
    logic       run_tick;
    logic       hour_key;
    logic       min_key;

    logic [3:0] min_1, min_2, hour_1, hour_2;
    logic       hour_oc;
    logic [3:0] m1_inc, m2_inc, h1_inc, h2_inc;
    logic       min_wrap;
    logic       hour_wrap;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= MODE_RUN;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (bus.key_mode) begin
            case (state)
                MODE_RUN:      state_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: state_nxt = MODE_SET_MIN;
                default:       state_nxt = MODE_RUN;
            endcase
        end
    end

    // Output decode; a key_inc coinciding with key_mode is dropped.
    always_comb begin
        bus.mode = state;
        run_tick = 1'b0;
        hour_key = 1'b0;
        min_key  = 1'b0;
        case (state)
            MODE_RUN:      run_tick = bus.sec_oc;
            MODE_SET_HOUR: hour_key = bus.key_inc && !bus.key_mode;
            MODE_SET_MIN:  min_key  = bus.key_inc && !bus.key_mode;
            default:       ;
        endcase
    end

    // BCD successors; >= compares keep any stray code collapsing to a legal value.
    always_comb begin
        m1_inc   = min_1 + 4'd1;
        m2_inc   = min_2;
        min_wrap = 1'b0;
        if (min_1 >= 4'd9) begin
            m1_inc = 4'd0;
            if (min_2 >= 4'd5) begin
                m2_inc   = 4'd0;
                min_wrap = 1'b1;
            end else begin
                m2_inc = min_2 + 4'd1;
            end
        end
        h1_inc    = hour_1 + 4'd1;
        h2_inc    = hour_2;
        hour_wrap = 1'b0;
        if (hour_2 >= 4'd2 && hour_1 >= 4'd3) begin
            h1_inc    = 4'd0;
            h2_inc    = 4'd0;
            hour_wrap = 1'b1;
        end else if (hour_1 >= 4'd9) begin
            h1_inc = 4'd0;
            h2_inc = hour_2 + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_1   <= 4'd0;
            min_2   <= 4'd0;
            hour_1  <= 4'd0;
            hour_2  <= 4'd0;
            hour_oc <= 1'b0;
        end else begin
            hour_oc <= 1'b0;
            if (run_tick || min_key) begin
                min_1 <= m1_inc;
                min_2 <= m2_inc;
            end
            // Hour carry only in RUN; a minute wrap in SET_MIN leaves hours alone.
            if ((run_tick && min_wrap) || hour_key) begin
                hour_1 <= h1_inc;
                hour_2 <= h2_inc;
            end
            if (run_tick && min_wrap && hour_wrap) hour_oc <= 1'b1;
        end
    end

    assign bus.min_1   = min_1;
    assign bus.min_2   = min_2;
    assign bus.hour_1  = hour_1;
    assign bus.hour_2  = hour_2;
    assign bus.hour_oc = hour_oc;

`ifdef MIN_HOUR_ALARM_EN
    logic [3:0] nh1, nh2;
    logic       alarm_hit;

    always_comb begin
        nh1 = min_wrap ? h1_inc : hour_1;
        nh2 = min_wrap ? h2_inc : hour_2;
    end

    // Compare against the time the RUN tick is about to load, so the pulse lines up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) alarm_hit <= 1'b0;
        else        alarm_hit <= run_tick &&
                                 ({nh2, nh1, m2_inc, m1_inc} ==
                                  {bus.al_hour_2, bus.al_hour_1, bus.al_min_2, bus.al_min_1});
    end

    assign bus.alarm_hit = alarm_hit;
`endif

endmodule

// File: tb/tb_min_hour_cnt.sv
// Directed bench for min_hour_cnt: a vector table plus hand-written multi-cycle sequences.
module tb_min_hour_cnt;
  logic clk;
  logic rst_n;
  min_hour_cnt_if bus();

  min_hour_cnt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int oc_seen  = 0;
  int oc_base  = 0;
  logic [18:0] exp_q[$];

  typedef struct {
    logic       r, s, m, i;
    logic [3:0] h2, h1, m2, m1;
    logic [1:0] md;
    logic       oc;
  } vec_t;
  vec_t vecs[12];

  // drivers: inputs applied 1 time unit after an edge, outputs sampled 1 unit after the next
  task automatic step(input logic r, input logic s, input logic m, input logic i);
    rst_n = r; bus.sec_oc = s; bus.key_mode = m; bus.key_inc = i;
    @(posedge clk);
    #1;
    rst_n = 1'b1; bus.sec_oc = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    if (bus.hour_oc) oc_seen++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard
  task automatic check_time(input string name, input logic [3:0] h2, input logic [3:0] h1,
                            input logic [3:0] m2, input logic [3:0] m1,
                            input logic [1:0] md, input logic oc);
    logic [18:0] exp_v;
    logic [18:0] act_v;
    exp_q.push_back({h2, h1, m2, m1, md, oc});
    exp_v = exp_q.pop_front();
    act_v = {bus.hour_2, bus.hour_1, bus.min_2, bus.min_1, bus.mode, bus.hour_oc};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h%0h:%0h%0h mode=%0d hour_oc=%0b, expected %0h%0h:%0h%0h mode=%0d hour_oc=%0b",
               name, act_v[18:15], act_v[14:11], act_v[10:7], act_v[6:3], act_v[2:1], act_v[0],
               exp_v[18:15], exp_v[14:11], exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.sec_oc = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
`ifdef MIN_HOUR_ALARM_EN
    bus.al_hour_2 = 4'd9; bus.al_hour_1 = 4'd9; bus.al_min_2 = 4'd9; bus.al_min_1 = 4'd9;
`endif
    #2;

    //                r     s     m     i     h2    h1    m2    m1    md     oc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 2'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd2, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'd0, 4'd2, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd3, 2'd2, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd3, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd0, 4'd3, 2'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0};

    reset_dut();
    check_time("reset_state", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      step(vecs[k].r, vecs[k].s, vecs[k].m, vecs[k].i);
      check_time($sformatf("vec%0d", k), vecs[k].h2, vecs[k].h1, vecs[k].m2, vecs[k].m1,
                 vecs[k].md, vecs[k].oc);
    end

    // 60 minute ticks spaced 3 cycles apart
    reset_dut();
    oc_base = oc_seen;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 0) check_time("first_tick", 4'd0, 4'd0, 4'd0, 4'd1, 2'd0, 1'b0);
      if (k == 9) check_time("min_carry_10", 4'd0, 4'd0, 4'd1, 4'd0, 2'd0, 1'b0);
      idle(2);
    end
    check_time("sixty_ticks", 4'd0, 4'd1, 4'd0, 4'd0, 2'd0, 1'b0);
    check_val("no_oc_sixty", oc_seen - oc_base, 0);

    // set 23:59 through the set modes, then day wrap
    reset_dut();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int h = 1; h <= 23; h++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_time($sformatf("set_hour_%0d", h), 4'(h / 10), 4'(h % 10), 4'd0, 4'd0, 2'd1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_time("set_2359", 4'd2, 4'd3, 4'd5, 4'd9, 2'd2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_time("run_2359", 4'd2, 4'd3, 4'd5, 4'd9, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_time("day_wrap", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_time("day_wrap_after", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);

    // 25 hour increments interleaved with 10 ignored ticks
    reset_dut();
    oc_base = oc_seen;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (k < 10) step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    check_time("set_hour_25", 4'd0, 4'd1, 4'd0, 4'd0, 2'd1, 1'b0);
    check_val("no_oc_set_hour", oc_seen - oc_base, 0);

    // SET_MIN at 12:59
    reset_dut();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_time("set_1259", 4'd1, 4'd2, 4'd5, 4'd9, 2'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_time("min_wrap_no_carry", 4'd1, 4'd2, 4'd0, 4'd0, 2'd2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_time("mode_beats_inc", 4'd1, 4'd2, 4'd0, 4'd0, 2'd0, 1'b0);

    // reset mid-set at 07:33 with a coincident tick
    reset_dut();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 33; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check_time("set_0733", 4'd0, 4'd7, 4'd3, 4'd3, 2'd2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_time("reset_mid_set", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_time("reset_tick_dropped", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);

`ifdef MIN_HOUR_ALARM_EN
    bus.al_hour_2 = 4'd0; bus.al_hour_1 = 4'd0; bus.al_min_2 = 4'd0; bus.al_min_1 = 4'd2;
    reset_dut();
    check_val("alarm_reset", int'(bus.alarm_hit), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("alarm_0001", int'(bus.alarm_hit), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_time("alarm_time", 4'd0, 4'd0, 4'd0, 4'd2, 2'd0, 1'b0);
    check_val("alarm_hit", int'(bus.alarm_hit), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("alarm_one_cycle", int'(bus.alarm_hit), 0);
    reset_dut();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("alarm_set_0001", int'(bus.alarm_hit), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_time("alarm_set_time", 4'd0, 4'd0, 4'd0, 4'd2, 2'd2, 1'b0);
    check_val("alarm_set_0002", int'(bus.alarm_hit), 0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
